// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the buffered UART.
package uart_pkg;

    localparam int DATA_BITS    = 8;
    localparam int OVERSAMPLE   = 16;
    localparam int START_SAMPLE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with first-word-fall-through head and occupancy count.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          level
);

    localparam int DEPTH = 1 << AW;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          level_q, level_d;
    logic                 do_push, do_pop;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_fifo.sv
// Buffered 8N1 UART: TX/RX FIFOs, programmable 16x baud divisor, sticky error flags.
//   state | meaning
//   IDLE  | TX: waiting for a queued byte / RX: waiting for a low line
//   START | start bit on the wire (TX) / start-bit qualification (RX)
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit; RX may hold here after a framing error until the line is high
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int FIFO_AW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [7:0]           tx_data,
    input  logic                 tx_write,
    output logic                 tx_full,
    output logic [FIFO_AW:0]     tx_level,
    output logic                 tx_busy,
    output logic [7:0]           rx_data,
    input  logic                 rx_read,
    output logic                 rx_empty,
    output logic [FIFO_AW:0]     rx_level,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
    input  logic                 err_clear,
    output logic                 txd,
    input  logic                 rxd
);

    localparam int TW = DIV_WIDTH + 4;

    // ---------------- TX ----------------
    uart_state_t          tx_state_q;
    logic [TW-1:0]        tx_timer_q;
    logic [TW-1:0]        tx_reload;
    logic [2:0]           tx_bit_q;
    logic [7:0]           tx_shift_q;
    logic                 txd_q;
    logic                 tx_empty;
    logic                 tx_pop;
    logic [7:0]           tx_head;

    // One bit is 16*(baud_div+1) clk; the down-counter runs reload..0 inclusive.
    assign tx_reload = {baud_div, 4'hF};
    assign tx_pop    = (tx_state_q == IDLE) && !tx_empty;
    assign tx_busy   = (tx_state_q != IDLE) || !tx_empty;
    assign txd       = txd_q;

    sync_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_write),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= IDLE;
            tx_timer_q <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            if (tx_timer_q != '0) tx_timer_q <= tx_timer_q - TW'(1);
            case (tx_state_q)
                IDLE: begin
                    if (!tx_empty) begin
                        tx_shift_q <= tx_head;
                        tx_timer_q <= tx_reload;
                        txd_q      <= 1'b0;
                        tx_state_q <= START;
                    end
                end
                START: begin
                    if (tx_timer_q == '0) begin
                        tx_timer_q <= tx_reload;
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= '0;
                        tx_state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tx_timer_q == '0) begin
                        tx_timer_q <= tx_reload;
                        if (tx_bit_q == 3'(DATA_BITS-1)) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= STOP;
                        end else begin
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tx_timer_q == '0) tx_state_q <= IDLE;
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    // ---------------- baud tick ----------------
    logic [DIV_WIDTH-1:0] baud_cnt_q;
    logic                 tick;

    // ">=" lets a lowered divisor take effect on the very next cycle.
    assign tick = (baud_cnt_q >= baud_div);

    always_ff @(posedge clk) begin
        if (reset)     baud_cnt_q <= '0;
        else if (tick) baud_cnt_q <= '0;
        else           baud_cnt_q <= baud_cnt_q + DIV_WIDTH'(1);
    end

    // ---------------- RX ----------------
    logic        rxd_meta_q, rxd_sync_q;
    uart_state_t rx_state_q;
    logic [3:0]  rx_tick_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_break_q;
    logic        rx_mid, rx_stop_sample, rx_push, rx_full;
    logic        rx_overrun_q, rx_frame_err_q;
    logic        overrun_set, frame_set;

    assign rx_mid         = tick && (rx_tick_q == 4'(OVERSAMPLE-1));
    assign rx_stop_sample = (rx_state_q == STOP) && !rx_break_q && rx_mid;
    assign rx_push        = rx_stop_sample && rxd_sync_q;
    assign frame_set      = rx_stop_sample && !rxd_sync_q;
    assign overrun_set    = rx_push && rx_full && !rx_read;

    sync_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_shift_q),
        .pop   (rx_read),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_break_q <= 1'b0;
        end else begin
            case (rx_state_q)
                IDLE: begin
                    if (!rxd_sync_q) begin
                        rx_tick_q  <= '0;
                        rx_state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_tick_q == 4'(START_SAMPLE-1)) begin
                            rx_tick_q  <= '0;
                            rx_bit_q   <= '0;
                            rx_state_q <= rxd_sync_q ? IDLE : DATA;
                        end else begin
                            rx_tick_q <= rx_tick_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (rx_mid) begin
                            rx_tick_q  <= '0;
                            rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
                            if (rx_bit_q == 3'(DATA_BITS-1)) rx_state_q <= STOP;
                            else                             rx_bit_q   <= rx_bit_q + 3'd1;
                        end else begin
                            rx_tick_q <= rx_tick_q + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (rx_break_q) begin
                        if (rxd_sync_q) begin
                            rx_break_q <= 1'b0;
                            rx_state_q <= IDLE;
                        end
                    end else if (tick) begin
                        if (rx_mid) begin
                            rx_tick_q <= '0;
                            if (rxd_sync_q) rx_state_q <= IDLE;
                            else            rx_break_q <= 1'b1;
                        end else begin
                            rx_tick_q <= rx_tick_q + 4'd1;
                        end
                    end
                end
                default: rx_state_q <= IDLE;
            endcase
        end
    end

    // A new error event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            if (overrun_set)    rx_overrun_q <= 1'b1;
            else if (err_clear) rx_overrun_q <= 1'b0;
            if (frame_set)      rx_frame_err_q <= 1'b1;
            else if (err_clear) rx_frame_err_q <= 1'b0;
        end
    end

    assign rx_overrun   = rx_overrun_q;
    assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo at 16x oversampling with baud_div mostly 0 (16 clk per bit).
module tb_uart_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] baud_div;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_full;
    logic [4:0]  tx_level;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_read;
    logic        rx_empty;
    logic [4:0]  rx_level;
    logic        rx_overrun;
    logic        rx_frame_err;
    logic        err_clear;
    logic        txd;
    logic        rxd;
    logic        rxd_drv;
    logic        loop_en;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rxd = loop_en ? txd : rxd_drv;

    uart_fifo #(.DIV_WIDTH(16), .FIFO_AW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_div     (baud_div),
        .tx_data      (tx_data),
        .tx_write     (tx_write),
        .tx_full      (tx_full),
        .tx_level     (tx_level),
        .tx_busy      (tx_busy),
        .rx_data      (rx_data),
        .rx_read      (rx_read),
        .rx_empty     (rx_empty),
        .rx_level     (rx_level),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .err_clear    (err_clear),
        .txd          (txd),
        .rxd          (rxd)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rd;
        logic       clr;
        int         exp_level;
        logic       exp_ferr;
        logic [7:0] exp_head;
    } rx_vec_t;

    rx_vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_read();
        rx_read = 1'b1;
        step(1);
        rx_read = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
    endtask

    task automatic pop_byte(output logic [7:0] b);
        b = rx_data;
        pulse_read();
    endtask

    // 8N1 frame on rxd_drv at 16 clk per bit (baud_div = 0)
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rxd_drv = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            step(16);
        end
        rxd_drv = stop_bit;
        step(16);
        rxd_drv = 1'b1;
        step(4);
    endtask

    // Mid-bit samples of one TX frame at 16 clk per bit: {stop, data, start}
    task automatic grab_frame(input int start, output logic [9:0] bits);
        for (int k = 0; k < 10; k++) begin
            wait_until(start + 16 * k + 8);
            bits[k] = txd;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          frames;
        logic [7:0]  b;
        logic [9:0]  bits;

        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 1, 1'b0, 8'h55};
        vecs[1] = '{8'hA3, 1'b1, 1'b0, 1'b0, 2, 1'b0, 8'h55};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 2, 1'b1, 8'h55};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 3, 1'b0, 8'h55};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 3, 1'b0, 8'hA3};
        vecs[5] = '{8'h81, 1'b0, 1'b1, 1'b1, 2, 1'b1, 8'h00};
        vecs[6] = '{8'h7E, 1'b1, 1'b1, 1'b0, 2, 1'b1, 8'hFF};

        reset     = 1'b1;
        baud_div  = 16'd0;
        tx_data   = 8'h00;
        tx_write  = 1'b0;
        rx_read   = 1'b0;
        err_clear = 1'b0;
        rxd_drv   = 1'b1;
        loop_en   = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);

        chk("reset txd", txd, 1);
        chk("reset tx_full", tx_full, 0);
        chk("reset tx_level", tx_level, 0);
        chk("reset tx_busy", tx_busy, 0);
        chk("reset rx_empty", rx_empty, 1);
        chk("reset rx_level", rx_level, 0);
        chk("reset rx_overrun", rx_overrun, 0);
        chk("reset rx_frame_err", rx_frame_err, 0);

        // RX vector table: optional clear/pop, then one frame, then check state
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].clr) pulse_clear();
            if (vecs[v].rd)  pulse_read();
            send_rx(vecs[v].data, vecs[v].stop);
            chk($sformatf("vec%0d rx_level", v), rx_level, vecs[v].exp_level);
            chk($sformatf("vec%0d rx_frame_err", v), rx_frame_err, vecs[v].exp_ferr);
            chk($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_head);
            chk($sformatf("vec%0d rx_overrun", v), rx_overrun, 0);
        end
        for (int i = 0; i < 20 && !rx_empty; i++) pulse_read();
        chk("drain rx_empty", rx_empty, 1);
        pulse_clear();
        chk("clear rx_frame_err", rx_frame_err, 0);

        // Loopback: 0x55 then 0xA3 at baud_div = 0
        loop_en = 1'b1;
        step(2);
        n0 = cyc;
        tx_data  = 8'h55;
        tx_write = 1'b1;
        step(1);
        chk("lb level N+1", tx_level, 1);
        chk("lb txd N+1", txd, 1);
        tx_data = 8'hA3;
        step(1);
        tx_write = 1'b0;
        chk("lb txd falls N+2", txd, 0);
        chk("lb level N+2", tx_level, 1);
        grab_frame(n0 + 2, bits);
        chk("lb frame1 bits", bits, {1'b1, 8'h55, 1'b0});
        wait_until(n0 + 162);
        chk("lb interframe idle", txd, 1);
        wait_until(n0 + 163);
        chk("lb frame2 start", txd, 0);
        grab_frame(n0 + 163, bits);
        chk("lb frame2 bits", bits, {1'b1, 8'hA3, 1'b0});
        wait_until(n0 + 350);
        chk("lb tx_busy done", tx_busy, 0);
        chk("lb rx_level", rx_level, 2);
        pop_byte(b);
        chk("lb rx byte0", b, 8'h55);
        pop_byte(b);
        chk("lb rx byte1", b, 8'hA3);
        chk("lb rx_empty", rx_empty, 1);
        chk("lb rx_frame_err", rx_frame_err, 0);
        chk("lb rx_overrun", rx_overrun, 0);
        loop_en = 1'b0;

        // Bit length at baud_div = 2: 48 clk per bit, 480 clk per frame
        baud_div = 16'd2;
        step(2);
        n0 = cyc;
        tx_data  = 8'h01;
        tx_write = 1'b1;
        step(1);
        tx_write = 1'b0;
        wait_until(n0 + 49);
        chk("div2 start bit end", txd, 0);
        wait_until(n0 + 50);
        chk("div2 bit0", txd, 1);
        wait_until(n0 + 481);
        chk("div2 busy last cycle", tx_busy, 1);
        wait_until(n0 + 482);
        chk("div2 busy cleared", tx_busy, 0);
        baud_div = 16'd0;
        step(2);

        // TX fill: 18 writes on consecutive cycles
        n0 = cyc;
        for (int i = 0; i < 18; i++) begin
            tx_data  = 8'(i + 1);
            tx_write = 1'b1;
            if (i == 16) chk("fill full at 16", tx_full, 0);
            if (i == 17) begin
                chk("fill full at 17", tx_full, 1);
                chk("fill level at 17", tx_level, 16);
            end
            step(1);
        end
        tx_write = 1'b0;
        chk("fill 18th dropped", tx_level, 16);
        frames = 0;
        wait_until(n0 + 2);
        while (cyc < n0 + 2 + 17 * 161 + 100) begin
            if (txd == 1'b0) begin
                frames++;
                wait_until(cyc + 160);
            end else begin
                step(1);
            end
        end
        chk("fill frame count", frames, 17);
        chk("fill tx_busy end", tx_busy, 0);
        chk("fill tx_level end", tx_level, 0);

        // Start-bit glitch: 4 clk low pulse
        rxd_drv = 1'b0;
        step(4);
        rxd_drv = 1'b1;
        step(200);
        chk("glitch rx_empty", rx_empty, 1);
        chk("glitch rx_frame_err", rx_frame_err, 0);
        chk("glitch rx_overrun", rx_overrun, 0);

        // RX overrun: 17 frames, no reads
        for (int i = 1; i <= 17; i++) send_rx(8'(i), 1'b1);
        chk("ovr rx_level", rx_level, 16);
        chk("ovr rx_overrun", rx_overrun, 1);
        for (int i = 1; i <= 16; i++) begin
            pop_byte(b);
            chk($sformatf("ovr byte%0d", i), b, i);
        end
        chk("ovr rx_empty", rx_empty, 1);
        chk("ovr flag sticky", rx_overrun, 1);
        pulse_clear();
        chk("ovr cleared", rx_overrun, 0);

        // Full RX FIFO, pop in the same cycle as the stop-bit sample
        for (int i = 0; i < 16; i++) send_rx(8'(8'h20 + i), 1'b1);
        chk("simpop full level", rx_level, 16);
        fork
            send_rx(8'h99, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 rx_read = 1'b1;
                @(posedge clk);
                #1 rx_read = 1'b0;
            end
        join
        chk("simpop level", rx_level, 16);
        chk("simpop rx_overrun", rx_overrun, 0);
        chk("simpop head", rx_data, 8'h21);
        for (int i = 0; i < 16; i++) pop_byte(b);
        chk("simpop last byte", b, 8'h99);
        chk("simpop rx_empty", rx_empty, 1);

        // Reset during TX data bit 3, RX holding one byte
        send_rx(8'h5A, 1'b1);
        chk("rst rx_level before", rx_level, 1);
        n0 = cyc;
        tx_write = 1'b1;
        tx_data  = 8'hF0;
        step(1);
        tx_data  = 8'h11;
        step(1);
        tx_data  = 8'h22;
        step(1);
        tx_write = 1'b0;
        wait_until(n0 + 70);
        chk("rst txd bit3 before", txd, 0);
        chk("rst tx_level before", tx_level, 2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst txd", txd, 1);
        chk("rst tx_level", tx_level, 0);
        chk("rst tx_busy", tx_busy, 0);
        chk("rst rx_empty", rx_empty, 1);
        chk("rst rx_level", rx_level, 0);
        step(30);
        chk("rst txd stays idle", txd, 1);
        chk("rst tx_busy stays 0", tx_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Buffered UART peripheral replacing the fixed-rate, unbuffered transmitter/receiver pair behind the SoC's `io` block. It adds a runtime-programmable baud divisor, parametrised-depth TX and RX FIFOs, sticky overrun and framing-error flags, and start-bit glitch rejection. The block sits between the `io` register decode and the `txd`/`rxd` pins. Frame format is fixed at 8N1, LSB first.

## Interface
Parameters:
- `DIV_WIDTH`, 16, width of the baud divisor.
- `FIFO_AW`, 4, log2 of the depth of each FIFO (default depth 16).

Ports:
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  synchronous reset, active-high; one clock domain.
- `baud_div`  in  DIV_WIDTH  oversample divisor; one 16x tick every `baud_div+1` clk. 325 gives 19200 baud.
- `tx_data`  in  8  byte to transmit.
- `tx_write`  in  1  push strobe for `tx_data`.
- `tx_full`  out  1  TX FIFO full.
- `tx_level`  out  FIFO_AW+1  TX FIFO occupancy.
- `tx_busy`  out  1  a frame is on the wire or the TX FIFO is non-empty.
- `rx_data`  out  8  head of the RX FIFO (first-word-fall-through). Valid only while `!rx_empty`.
- `rx_read`  in  1  pop strobe.
- `rx_empty`  out  1  RX FIFO empty.
- `rx_level`  out  FIFO_AW+1  RX FIFO occupancy.
- `rx_overrun`  out  1  sticky: a received byte was dropped.
- `rx_frame_err`  out  1  sticky: a stop bit was sampled low.
- `err_clear`  in  1  clears both sticky flags.
- `txd`  out  1  serial output; idles high.
- `rxd`  in  1  serial input; asynchronous to `clk`.

## Operation
- **FIFO rules (both FIFOs)**
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - A pop on an empty FIFO is ignored. Push and pop in the same cycle on an empty FIFO performs the push only.
  - Pointers wrap modulo 2^FIFO_AW.
  - Level range is 0..2^FIFO_AW.
- **TX FSM (IDLE, START, DATA, STOP)**
  - IDLE: when the FIFO is non-empty, pop into the shifter, drive `txd`=0 and go to START.
  - Each bit lasts exactly 16*(`baud_div`+1) clk, timed by a TX-local counter that restarts at every frame start.
  - DATA shifts out 8 bits, LSB first. STOP drives 1 for one bit, then returns to IDLE.
  - Frames are back-to-back: IDLE is re-entered and the next pop happens on the cycle after STOP ends.
- **Baud generator (RX):** a free-running counter 0..`baud_div` produces a 1-cycle tick when it wraps. A `baud_div` change takes effect at the next wrap. If the counter exceeds the new value, it wraps on the next cycle.
- **RX path:** `rxd` passes through a 2-FF synchroniser, then an RX FSM (IDLE, START, DATA, STOP).
  - IDLE: a low sample moves to START and clears the tick count.
  - START: at tick 8, a high sample (glitch) returns to IDLE with nothing recorded. A low sample moves to DATA.
  - DATA: 8 samples, one every 16 ticks (mid-bit), LSB first.
  - STOP: sampled mid-bit.
    - High: push the byte. If the push is refused (full, no simultaneous pop), drop the byte and set `rx_overrun`.
    - Low: set `rx_frame_err`, discard the byte and wait in STOP until the line is high before returning to IDLE.
- **Error flags:** `err_clear` together with a new error event in the same cycle leaves the flag set.
- **Reset mid-frame:** the frame is aborted and both FIFOs are emptied. TX does not finish the frame in progress.
- **Reset values:** `txd`=1, `tx_full`=0, `tx_level`=0, `tx_busy`=0, `rx_empty`=1, `rx_level`=0, `rx_overrun`=0, `rx_frame_err`=0. FSMs in IDLE.

## Timing
- TX: with `tx_write` at cycle N into an idle block, the FIFO is non-empty at N+1, the pop occurs at N+1 and `txd` falls at N+2.
- Frame length is 160*(`baud_div`+1) clk exactly.
- RX: `rx_empty` falls 1 cycle after the stop-bit sample. The end-to-end latency from the `rxd` stop-bit midpoint is 2 synchroniser cycles plus up to `baud_div`+1 tick jitter plus 1.
- Flags, levels and `rx_data` are registered or read straight from FIFO registers. `rx_data` updates the cycle after a pop.

## Structure
- Package `uart_pkg`:
  - constants `DATA_BITS`=8, `OVERSAMPLE`=16, `START_SAMPLE`=8;
  - enum `uart_state_t` {IDLE, START, DATA, STOP}, shared by both FSMs.
- Sub-module `sync_fifo` (parameter `AW`; outputs `full`, `empty`, `level`; FWFT head output), instantiated twice.
- TX, RX and the baud generator stay inline in `uart_fifo`.

## Test plan
- **Loopback:** `baud_div`=0, `txd` tied to `rxd`, write 0x55 then 0xA3 → each frame is 160 clk, `rx_data` reads 0x55 then 0xA3, no error flags.
- **TX fill:** write 18 bytes on consecutive cycles → 17 accepted (1 in the shifter, 16 queued), `tx_full`=1 from cycle 17, 18th dropped; `txd` emits exactly 17 frames.
- **RX overrun:** drive 17 frames into `rxd` without reads → `rx_level`=16, `rx_overrun`=1; reads return bytes 1..16 in order; `err_clear` → 0.
- **Framing and glitch:** stop bit driven 0 → `rx_frame_err`=1 and `rx_level` unchanged. A 4-clk low pulse at `baud_div`=0 → no byte and no flag.
- **Simultaneous RX pop:** RX FIFO full, `rx_read` asserted in the same cycle as the stop sample → byte accepted, `rx_overrun`=0, level stays 16.
- **Reset mid-frame:** `reset` during TX DATA bit 3 → `txd`=1 on the next cycle, `tx_level`=0, `tx_busy`=0; `rx_empty`=1.
